// File: rtl/instr_seq_ctrl.sv
// Multicycle instruction sequencer: walks each fetched word through DECODE, EXEC,
// MEM and WB, iterating vector ALU and vector memory operations over VLEN lanes.
module instr_seq_ctrl #(
    parameter  int VLEN = 4,
    localparam int LW   = $clog2(VLEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          imem_valid,
    input  logic [31:0]   inst,
    output logic          inst_ready,
    output logic [31:0]   ir,
    output logic          dec_en,
    output logic          alu_en,
    output logic          vec_en,
    output logic [LW-1:0] lane,
    output logic          mem_req,
    output logic          mem_we,
    input  logic          mem_ack,
    input  logic          branch_taken,
    output logic          rf_we,
    output logic          vrf_we,
    output logic          pc_en,
    output logic          jump_en,
    output logic          illegal,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_RST,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    localparam logic [LW-1:0] LANE_MAX = LW'(VLEN - 1);

    state_t        state, state_nxt;
    logic [31:0]   ir_nxt;
    logic [LW-1:0] lane_nxt;
    logic          jump_q, jump_nxt;

    // Instruction classification, all taken from the latched word.
    logic is_alu, is_mem, is_ctl, is_vec, is_reg, is_store, is_load, is_ill;
    logic lane_last;

    always_comb begin
        is_alu    = ~ir[31];
        is_mem    = (ir[31:30] == 2'b10);
        is_ctl    = (ir[31:30] == 2'b11);
        is_vec    = ir[29];
        is_reg    = ir[28];
        is_store  = is_mem & ir[27];
        is_load   = is_mem & ~ir[27];
        is_ill    = is_ctl & is_vec;
        lane_last = (lane == LANE_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_RST;
            ir     <= '0;
            lane   <= '0;
            jump_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            ir     <= ir_nxt;
            lane   <= lane_nxt;
            jump_q <= jump_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ir_nxt     = ir;
        lane_nxt   = lane;
        jump_nxt   = jump_q;
        inst_ready = 1'b0;
        dec_en     = 1'b0;
        alu_en     = 1'b0;
        vec_en     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        rf_we      = 1'b0;
        vrf_we     = 1'b0;
        pc_en      = 1'b0;
        jump_en    = 1'b0;
        illegal    = 1'b0;
        busy       = 1'b0;

        case (state)
            S_RST: begin
                state_nxt = S_FETCH;
            end

            S_FETCH: begin
                inst_ready = 1'b1;
                if (imem_valid) begin
                    ir_nxt    = inst;
                    state_nxt = S_DECODE;
                end
            end

            S_DECODE: begin
                busy   = 1'b1;
                dec_en = 1'b1;
                if (is_ill) begin
                    // Illegal words skip execution but still advance the PC.
                    illegal   = 1'b1;
                    pc_en     = 1'b1;
                    state_nxt = S_FETCH;
                end else begin
                    lane_nxt  = '0;
                    jump_nxt  = 1'b0;
                    state_nxt = S_EXEC;
                end
            end

            S_EXEC: begin
                busy = 1'b1;
                if (is_alu && is_vec) begin
                    vec_en = 1'b1;
                    if (lane_last) begin
                        lane_nxt  = '0;
                        state_nxt = S_WB;
                    end else begin
                        lane_nxt = lane + LW'(1);
                    end
                end else begin
                    alu_en = 1'b1;
                    if (is_mem) begin
                        lane_nxt  = '0;
                        state_nxt = S_MEM;
                    end else begin
                        if (is_ctl) jump_nxt = is_reg | branch_taken;
                        state_nxt = S_WB;
                    end
                end
            end

            S_MEM: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                mem_we  = is_store;
                // Request stays up across lanes; only an ack moves it on.
                if (mem_ack) begin
                    if (!is_vec || lane_last) begin
                        lane_nxt  = '0;
                        state_nxt = S_WB;
                    end else begin
                        lane_nxt = lane + LW'(1);
                    end
                end
            end

            S_WB: begin
                busy      = 1'b1;
                pc_en     = 1'b1;
                jump_en   = is_ctl & jump_q;
                rf_we     = ~is_vec & (is_alu | is_load);
                vrf_we    = is_vec & (is_alu | is_load);
                state_nxt = S_FETCH;
            end

            default: begin
                state_nxt = S_RST;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Bench for instr_seq_ctrl: a latency/flag table, reset sequences, and random
// instructions checked cycle by cycle against a transaction-level trace model.
module tb_instr_seq_ctrl;

    localparam int VLEN = 4;

    typedef struct packed {
        logic       inst_ready;
        logic       dec_en;
        logic       alu_en;
        logic       vec_en;
        logic [1:0] lane;
        logic       mem_req;
        logic       mem_we;
        logic       rf_we;
        logic       vrf_we;
        logic       pc_en;
        logic       jump_en;
        logic       illegal;
        logic       busy;
    } obs_t;

    typedef struct {
        logic [31:0] ins;
        logic        bt;
        int          wlane;
        int          wcyc;
        int          lat;
        logic        rf;
        logic        vrf;
        logic        jmp;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_valid = 1'b0;
    logic [31:0] inst = '0;
    logic        mem_ack = 1'b0;
    logic        branch_taken = 1'b0;
    logic        inst_ready, dec_en, alu_en, vec_en, mem_req, mem_we;
    logic        rf_we, vrf_we, pc_en, jump_en, illegal, busy;
    logic [31:0] ir;
    logic [1:0]  lane;
    obs_t        obs;

    int total = 0;
    int bad   = 0;

    obs_t exp_q[$];
    logic ack_q[$];
    logic bt_q[$];

    instr_seq_ctrl #(.VLEN(VLEN)) dut (
        .clk(clk), .rst_n(rst_n), .imem_valid(imem_valid), .inst(inst),
        .inst_ready(inst_ready), .ir(ir), .dec_en(dec_en), .alu_en(alu_en),
        .vec_en(vec_en), .lane(lane), .mem_req(mem_req), .mem_we(mem_we),
        .mem_ack(mem_ack), .branch_taken(branch_taken), .rf_we(rf_we),
        .vrf_we(vrf_we), .pc_en(pc_en), .jump_en(jump_en), .illegal(illegal),
        .busy(busy)
    );

    assign obs = {inst_ready, dec_en, alu_en, vec_en, lane, mem_req, mem_we,
                  rf_we, vrf_we, pc_en, jump_en, illegal, busy};

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic obs_t fetch_obs();
        obs_t e;
        e = '0;
        e.inst_ready = 1'b1;
        return e;
    endfunction

    task automatic push(input obs_t e, input logic a, input logic b);
        exp_q.push_back(e);
        ack_q.push_back(a);
        bt_q.push_back(b);
    endtask

    // Expected per-cycle trace of one instruction, from handshake to its last cycle.
    task automatic build(input logic [31:0] ins, input int w[VLEN]);
        obs_t e;
        logic alu, mem, ctl, v, r, st, jmp, b;
        int   n;
        exp_q.delete(); ack_q.delete(); bt_q.delete();
        alu = (ins[31:30] == 2'b00) || (ins[31:30] == 2'b01);
        mem = (ins[31:30] == 2'b10);
        ctl = (ins[31:30] == 2'b11);
        v = ins[29]; r = ins[28]; st = ins[27];
        push(fetch_obs(), 1'($urandom), 1'($urandom));
        e = '0; e.dec_en = 1'b1; e.busy = 1'b1;
        if (ctl && v) begin
            e.illegal = 1'b1; e.pc_en = 1'b1;
            push(e, 1'($urandom), 1'($urandom));
            return;
        end
        push(e, 1'($urandom), 1'($urandom));
        jmp = 1'b0;
        if (alu && v) begin
            for (int l = 0; l < VLEN; l++) begin
                e = '0; e.vec_en = 1'b1; e.lane = 2'(l); e.busy = 1'b1;
                push(e, 1'($urandom), 1'($urandom));
            end
        end else begin
            e = '0; e.alu_en = 1'b1; e.busy = 1'b1;
            b = 1'($urandom);
            jmp = r | b;
            push(e, 1'($urandom), b);
        end
        if (mem) begin
            n = v ? VLEN : 1;
            for (int l = 0; l < n; l++) begin
                e = '0; e.mem_req = 1'b1; e.mem_we = st; e.lane = 2'(l); e.busy = 1'b1;
                for (int c = 0; c < w[l]; c++) push(e, 1'b0, 1'($urandom));
                push(e, 1'b1, 1'($urandom));
            end
        end
        e = '0; e.pc_en = 1'b1; e.busy = 1'b1;
        e.rf_we   = !v && (alu || (mem && !st));
        e.vrf_we  = v && (alu || (mem && !st));
        e.jump_en = ctl && jmp;
        push(e, 1'($urandom), 1'($urandom));
    endtask

    // Entered and left one time unit after a rising edge with the DUT in FETCH.
    task automatic run_model(input logic [31:0] ins, input int w[VLEN]);
        build(ins, w);
        for (int k = 0; k < exp_q.size(); k++) begin
            imem_valid   = (k == 0) ? 1'b1 : 1'($urandom);
            inst         = (k == 0) ? ins : $urandom;
            mem_ack      = ack_q[k];
            branch_taken = bt_q[k];
            @(negedge clk);
            check($sformatf("trace %h cyc%0d", ins, k), 64'(obs), 64'(exp_q[k]));
            if (k >= 1) check($sformatf("ir hold %h cyc%0d", ins, k), 64'(ir), 64'(ins));
            @(posedge clk); #1;
        end
        imem_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            imem_valid = 1'b0;
            mem_ack    = 1'($urandom);
            @(negedge clk);
            check("idle fetch", 64'(obs), 64'(fetch_obs()));
            @(posedge clk); #1;
        end
    endtask

    task automatic run_vec(input vec_t t, input int idx);
        int   cyc, wc;
        bit   done;
        obs_t at;
        at = '0;
        imem_valid = 1'b1; inst = t.ins; branch_taken = t.bt; mem_ack = 1'b1;
        @(posedge clk); #1;
        imem_valid = 1'b0; cyc = 1; wc = t.wcyc; done = 1'b0;
        while (!done && cyc < 40) begin
            if (mem_req && int'(lane) == t.wlane && wc > 0) begin
                mem_ack = 1'b0; wc--;
            end else begin
                mem_ack = 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (pc_en) begin done = 1'b1; at = obs; end
            @(posedge clk); #1;
        end
        check($sformatf("vec%0d pc_en seen", idx), 64'(done), 64'(1));
        check($sformatf("vec%0d latency", idx), 64'(cyc), 64'(t.lat));
        check($sformatf("vec%0d rf_we", idx), 64'(at.rf_we), 64'(t.rf));
        check($sformatf("vec%0d vrf_we", idx), 64'(at.vrf_we), 64'(t.vrf));
        check($sformatf("vec%0d jump_en", idx), 64'(at.jump_en), 64'(t.jmp));
        check($sformatf("vec%0d illegal", idx), 64'(at.illegal), 64'(t.ill));
        @(negedge clk);
        check($sformatf("vec%0d back to fetch", idx), 64'(obs), 64'(fetch_obs()));
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t tbl[$];
        int   w[VLEN];
        bit   hit;

        //            ins            bt    wl wc lat rf    vrf   jmp   ill
        tbl.push_back('{32'h0010_8400, 1'b0, 0, 0, 4, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{32'h5000_0000, 1'b1, 0, 0, 4, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{32'h3000_0000, 1'b0, 0, 0, 7, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{32'h7000_0000, 1'b0, 0, 0, 7, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{32'h8000_0000, 1'b0, 0, 0, 5, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{32'h8000_0000, 1'b0, 0, 3, 8, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{32'h8800_0000, 1'b0, 0, 0, 5, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{32'hA000_0000, 1'b0, 0, 0, 8, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{32'hA800_0000, 1'b0, 1, 2, 10, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{32'hC000_0000, 1'b1, 0, 0, 4, 1'b0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{32'hC000_0000, 1'b0, 0, 0, 4, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{32'hD000_0000, 1'b0, 0, 0, 4, 1'b0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{32'hE000_0000, 1'b0, 0, 0, 2, 1'b0, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{32'hF000_0000, 1'b1, 0, 0, 2, 1'b0, 1'b0, 1'b0, 1'b1});

        // Power-on reset, then release away from the edge.
        @(negedge clk);
        check("reset outputs", 64'(obs), 64'(0));
        check("reset ir", 64'(ir), 64'(0));
        #1 rst_n = 1'b1;
        #1 check("rst state after release", 64'(obs), 64'(0));
        @(negedge clk);
        check("fetch after rst", 64'(obs), 64'(fetch_obs()));
        @(posedge clk); #1;

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

        // Reset while a vector store is waiting on its first ack.
        imem_valid = 1'b1; inst = 32'hA800_0000; mem_ack = 1'b0;
        @(posedge clk); #1;
        imem_valid = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            if (mem_req) hit = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("reached MEM before reset", 64'(hit), 64'(1));
        #2 rst_n = 1'b0;
        #1 check("async reset outputs", 64'(obs), 64'(0));
        check("async reset ir", 64'(ir), 64'(0));
        @(negedge clk); #1;
        rst_n = 1'b1; mem_ack = 1'b1;
        #1 check("rst state mid-op release", 64'(obs), 64'(0));
        @(negedge clk);
        check("fetch after mid-op reset", 64'(obs), 64'(fetch_obs()));
        @(posedge clk); #1;

        // Random instructions with random ack stalls per lane.
        for (int n = 0; n < 150; n++) begin
            for (int l = 0; l < VLEN; l++)
                w[l] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            idle(int'($urandom_range(0, 1)));
            run_model($urandom, w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
